// File: rtl/display_mode_scheduler.sv
// Chooses which HEX view is shown: debounced key steps through the views,
// auto rotation steps on DCF77 seconds, and the switches override both.
module display_mode_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DWELL_HM        = 20,
  parameter int unsigned DWELL_OTHER     = 4,
  parameter int unsigned HOLD_S          = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       key_n,
  input  logic [2:0] SW,
  input  logic       auto_en,
  output logic [2:0] sel,
  output logic [1:0] mode,
  output logic       key_event
);

  localparam int unsigned DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned DWELL_MAX = (DWELL_HM > DWELL_OTHER) ? DWELL_HM : DWELL_OTHER;
  localparam int unsigned DW_W      = (DWELL_MAX > 1) ? $clog2(DWELL_MAX + 1) : 1;
  localparam int unsigned HOLD_W    = (HOLD_S > 1) ? $clog2(HOLD_S + 1) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0]   LIM_HM    = DW_W'(DWELL_HM - 1);
  localparam logic [DW_W-1:0]   LIM_OTHER = DW_W'(DWELL_OTHER - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_S);

  typedef enum logic [1:0] {
    M_HM   = 2'd0,
    M_SEC  = 2'd1,
    M_DAY  = 2'd2,
    M_DATE = 2'd3
  } mode_e;

  logic            key_s1, key_s2, db_level, db_level_d;
  logic [DB_W-1:0] db_cnt;

  mode_e             state, state_nxt;
  logic [DW_W-1:0]   dwell_cnt, dwell_nxt, lim_m1;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [2:0]        sel_nxt;
  logic              ovr, key_eff, auto_active, expire, advance;

  // Key path: synchronizer, stability counter, falling-edge event one cycle after the level flips.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_s1     <= 1'b1;
      key_s2     <= 1'b1;
      db_level   <= 1'b1;
      db_level_d <= 1'b1;
      db_cnt     <= '0;
      key_event  <= 1'b0;
    end else begin
      key_s1     <= key_n;
      key_s2     <= key_s1;
      db_level_d <= db_level;
      key_event  <= db_level_d & ~db_level;
      if (key_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= key_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Next view, dwell/hold counters and view select.
  always_comb begin
    ovr         = |SW;
    key_eff     = key_event & ~ovr;
    auto_active = auto_en & (hold_cnt == '0) & ~ovr;
    lim_m1      = (state == M_HM) ? LIM_HM : LIM_OTHER;
    expire      = auto_active & tick_1hz & (dwell_cnt == lim_m1);
    advance     = key_eff | expire;

    state_nxt = state;
    if (advance) state_nxt = mode_e'(2'(state) + 2'd1);

    dwell_nxt = dwell_cnt;
    if (advance || key_eff || !auto_en || ovr) dwell_nxt = '0;
    else if (tick_1hz && auto_active)          dwell_nxt = dwell_cnt + DW_W'(1);

    hold_nxt = hold_cnt;
    if (key_eff)                            hold_nxt = HOLD_LOAD;
    else if (tick_1hz && hold_cnt != '0)    hold_nxt = hold_cnt - HOLD_W'(1);

    if (!ovr)       sel_nxt = {state_nxt == M_DATE, state_nxt == M_DAY, state_nxt == M_SEC};
    else if (SW[0]) sel_nxt = 3'b001;
    else if (SW[1]) sel_nxt = 3'b010;
    else            sel_nxt = 3'b100;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= M_HM;
      dwell_cnt <= '0;
      hold_cnt  <= '0;
      sel       <= 3'b000;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      hold_cnt  <= hold_nxt;
      sel       <= sel_nxt;
    end
  end

  assign mode = 2'(state);

endmodule

// File: tb/tb_display_mode_scheduler.sv
// Directed bench for display_mode_scheduler with short debounce/dwell/hold settings.
module tb_display_mode_scheduler;

  logic       clk = 1'b0;
  logic       reset_n, tick_1hz, key_n, auto_en;
  logic [2:0] sw;
  logic [2:0] sel;
  logic [1:0] mode;
  logic       key_event;

  int n_vec  = 0;
  int n_fail = 0;
  int ev_cnt = 0;

  always #5 clk = ~clk;

  display_mode_scheduler #(
    .DEBOUNCE_CYCLES(4), .DWELL_HM(5), .DWELL_OTHER(2), .HOLD_S(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz), .key_n(key_n),
    .SW(sw), .auto_en(auto_en), .sel(sel), .mode(mode), .key_event(key_event)
  );

  always @(negedge clk) if (reset_n && key_event) ev_cnt++;

  typedef struct {
    logic       auto_on;
    logic [2:0] sw;
    logic       press;
    int         ticks;
    logic [2:0] exp_sel;
    logic [1:0] exp_mode;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    step(9);
  endtask

  task automatic press();
    key_n = 1'b0;
    step(12);
    key_n = 1'b1;
    step(12);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
  endtask

  initial begin
    // auto rotation: 30 ticks
    tbl[0]  = '{1'b1, 3'b000, 1'b0, 4, 3'b000, 2'd0};
    tbl[1]  = '{1'b1, 3'b000, 1'b0, 1, 3'b001, 2'd1};
    tbl[2]  = '{1'b1, 3'b000, 1'b0, 1, 3'b001, 2'd1};
    tbl[3]  = '{1'b1, 3'b000, 1'b0, 1, 3'b010, 2'd2};
    tbl[4]  = '{1'b1, 3'b000, 1'b0, 2, 3'b100, 2'd3};
    tbl[5]  = '{1'b1, 3'b000, 1'b0, 2, 3'b000, 2'd0};
    tbl[6]  = '{1'b1, 3'b000, 1'b0, 5, 3'b001, 2'd1};
    tbl[7]  = '{1'b1, 3'b000, 1'b0, 4, 3'b100, 2'd3};
    tbl[8]  = '{1'b1, 3'b000, 1'b0, 2, 3'b000, 2'd0};
    tbl[9]  = '{1'b1, 3'b000, 1'b0, 7, 3'b010, 2'd2};
    tbl[10] = '{1'b1, 3'b000, 1'b0, 1, 3'b010, 2'd2};
    // override in DAY, then resume with dwell restarted
    tbl[11] = '{1'b1, 3'b110, 1'b0, 3, 3'b010, 2'd2};
    tbl[12] = '{1'b1, 3'b110, 1'b1, 0, 3'b010, 2'd2};
    tbl[13] = '{1'b1, 3'b000, 1'b0, 0, 3'b010, 2'd2};
    tbl[14] = '{1'b1, 3'b000, 1'b0, 1, 3'b010, 2'd2};
    tbl[15] = '{1'b1, 3'b000, 1'b0, 1, 3'b100, 2'd3};
    tbl[16] = '{1'b1, 3'b001, 1'b0, 0, 3'b001, 2'd3};
    tbl[17] = '{1'b1, 3'b011, 1'b0, 0, 3'b001, 2'd3};
    tbl[18] = '{1'b1, 3'b100, 1'b0, 1, 3'b100, 2'd3};
    tbl[19] = '{1'b1, 3'b010, 1'b0, 0, 3'b010, 2'd3};
    tbl[20] = '{1'b1, 3'b000, 1'b0, 0, 3'b100, 2'd3};
    // key press in HM at dwell 3 suspends rotation for HOLD_S ticks
    tbl[21] = '{1'b1, 3'b000, 1'b0, 2, 3'b000, 2'd0};
    tbl[22] = '{1'b1, 3'b000, 1'b0, 3, 3'b000, 2'd0};
    tbl[23] = '{1'b1, 3'b000, 1'b1, 0, 3'b001, 2'd1};
    tbl[24] = '{1'b1, 3'b000, 1'b0, 3, 3'b001, 2'd1};
    tbl[25] = '{1'b1, 3'b000, 1'b0, 1, 3'b001, 2'd1};
    tbl[26] = '{1'b1, 3'b000, 1'b0, 1, 3'b010, 2'd2};
    // auto disabled: ticks ignored, key still steps
    tbl[27] = '{1'b0, 3'b000, 1'b0, 6, 3'b010, 2'd2};
    tbl[28] = '{1'b0, 3'b000, 1'b1, 0, 3'b100, 2'd3};

    reset_n  = 1'b0;
    key_n    = 1'b1;
    sw       = 3'b000;
    auto_en  = 1'b0;
    tick_1hz = 1'b0;
    step(2);
    check("reset_sel", sel, 3'b000);
    check("reset_mode", mode, 2'd0);
    check("reset_key_event", key_event, 1'b0);
    reset_n = 1'b1;
    step(2);

    // glitch shorter than debounce window
    key_n = 1'b0;
    step(3);
    key_n = 1'b1;
    step(10);
    check("glitch_events", ev_cnt, 0);
    check("glitch_sel", sel, 3'b000);

    // stable press: key_event at +7, sel at +8
    key_n = 1'b0;
    step(7);
    check("lat_sel_before", sel, 3'b000);
    check("lat_key_event", key_event, 1'b1);
    step(1);
    check("lat_sel_after", sel, 3'b001);
    check("lat_mode_after", mode, 2'd1);
    check("lat_key_event_drop", key_event, 1'b0);
    step(2);
    key_n = 1'b1;
    step(12);
    check("press_events", ev_cnt, 1);
    check("release_sel", sel, 3'b001);

    // walk to DATE, hold 3 -> 2, then asynchronous reset
    press();
    press();
    tick_once();
    check("pre_reset_mode", mode, 2'd3);
    check("pre_reset_sel", sel, 3'b100);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_sel", sel, 3'b000);
    check("async_mode", mode, 2'd0);
    check("async_key_event", key_event, 1'b0);
    step(2);
    reset_n = 1'b1;
    step(2);
    press();
    check("post_reset_press_sel", sel, 3'b001);
    check("post_reset_press_mode", mode, 2'd1);

    // table-driven rotation / override / hold
    do_reset();
    for (int i = 0; i < NV; i++) begin
      auto_en = tbl[i].auto_on;
      sw      = tbl[i].sw;
      step(2);
      if (tbl[i].press) press();
      for (int t = 0; t < tbl[i].ticks; t++) tick_once();
      check($sformatf("tbl%0d_sel", i), sel, tbl[i].exp_sel);
      check($sformatf("tbl%0d_mode", i), mode, tbl[i].exp_mode);
    end

    // key event and dwell expiry in the same cycle
    sw      = 3'b000;
    auto_en = 1'b1;
    do_reset();
    for (int t = 0; t < 4; t++) tick_once();
    check("coinc_pre_mode", mode, 2'd0);
    key_n = 1'b0;
    step(7);
    check("coinc_key_event", key_event, 1'b1);
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    check("coinc_mode", mode, 2'd1);
    check("coinc_sel", sel, 3'b001);
    step(4);
    key_n = 1'b1;
    step(12);
    for (int t = 0; t < 4; t++) tick_once();
    check("coinc_hold_mode", mode, 2'd1);
    tick_once();
    check("coinc_resume_mode", mode, 2'd2);
    check("coinc_resume_sel", sel, 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
